wb_write_arbiter: RTL and testbench

Writeback-side writer for the 32x32 register file. Merges two write sources onto the file's single write port (wr/waddr/din, sampled on posedge clk). The in-order pipeline WB stage has absolute priority. Long-latency unit (mult/div) results arrive by valid/ready and wait in a small FIFO until a free write slot. Also reports pending buffered destinations so decode can stall RAW hazards.

---
 rtl/wb_write_arbiter_if.sv | 35 +++
 rtl/wb_write_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_write_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_if.sv
// Bundle of the writeback arbiter's pipe, long-latency, register-file and hazard-check signals.
// The arbiter takes the slave view; the surrounding pipeline takes the master view.
interface wb_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              pipe_wr;
    logic [ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_din;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_waddr;
    logic [DATA_W-1:0] lu_din;
    logic              rf_wr;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_din;
    logic [ADDR_W-1:0] chk_addr1;
    logic [ADDR_W-1:0] chk_addr2;
    logic              chk_hit1;
    logic              chk_hit2;
    logic [CNT_W-1:0]  pend_cnt;

    modport master (
        output pipe_wr, pipe_waddr, pipe_din, lu_valid, lu_waddr, lu_din, chk_addr1, chk_addr2,
        input  lu_ready, rf_wr, rf_waddr, rf_din, chk_hit1, chk_hit2, pend_cnt
    );

    modport slave (
        input  pipe_wr, pipe_waddr, pipe_din, lu_valid, lu_waddr, lu_din, chk_addr1, chk_addr2,
        output lu_ready, rf_wr, rf_waddr, rf_din, chk_hit1, chk_hit2, pend_cnt
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Merges the WB stage and a buffered long-latency result stream onto the single register-file
// write port. WB always wins; buffered results that a younger WB write supersedes are killed.
module wb_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    wb_write_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [DEPTH-1:0]  kill_r;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              rf_wr_r;
    logic [ADDR_W-1:0] rf_waddr_r;
    logic [DATA_W-1:0] rf_din_r;

    logic              pipe_eff_s;
    logic              lu_ready_s;
    logic              push_s;
    logic              pop_s;
    logic [DEPTH-1:0]  live_s;
    logic              hit1_s;
    logic              hit2_s;

    // Handshake, slot selection and hazard lookup over the live (occupied, unkilled) entries
    always_comb begin
        pipe_eff_s = bus.pipe_wr && (bus.pipe_waddr != {ADDR_W{1'b0}});
        lu_ready_s = (count_r < CNT_W'(DEPTH)) && !rst;
        push_s     = bus.lu_valid && lu_ready_s && (bus.lu_waddr != {ADDR_W{1'b0}});
        pop_s      = !pipe_eff_s && (count_r != {CNT_W{1'b0}});
        hit1_s     = 1'b0;
        hit2_s     = 1'b0;
        live_s     = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            // Slot i is occupied when its distance from head is below the occupancy count.
            live_s[i] = (CNT_W'(PTR_W'(PTR_W'(i) - head_r)) < count_r) && !kill_r[i];
            hit1_s    = hit1_s | (live_s[i] && (bus.chk_addr1 != {ADDR_W{1'b0}})
                                  && (addr_mem_r[i] == bus.chk_addr1));
            hit2_s    = hit2_s | (live_s[i] && (bus.chk_addr2 != {ADDR_W{1'b0}})
                                  && (addr_mem_r[i] == bus.chk_addr2));
        end
    end

    // FIFO storage, kill tracking and the registered register-file write port
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_r    <= 1'b0;
            rf_waddr_r <= {ADDR_W{1'b0}};
            rf_din_r   <= {DATA_W{1'b0}};
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            kill_r     <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {ADDR_W{1'b0}};
                data_mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (pipe_eff_s) begin
                rf_wr_r    <= 1'b1;
                rf_waddr_r <= bus.pipe_waddr;
                rf_din_r   <= bus.pipe_din;
            end else if (pop_s) begin
                rf_wr_r    <= !kill_r[head_r];
                rf_waddr_r <= addr_mem_r[head_r];
                rf_din_r   <= data_mem_r[head_r];
            end else begin
                rf_wr_r    <= 1'b0;
                rf_waddr_r <= rf_waddr_r;
                rf_din_r   <= rf_din_r;
            end

            // A WB write is younger than anything buffered, so matching entries become stale.
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_eff_s && (addr_mem_r[i] == bus.pipe_waddr)) begin
                    kill_r[i] <= 1'b1;
                end else begin
                    kill_r[i] <= kill_r[i];
                end
            end

            if (push_s) begin
                addr_mem_r[tail_r] <= bus.lu_waddr;
                data_mem_r[tail_r] <= bus.lu_din;
                kill_r[tail_r]     <= pipe_eff_s && (bus.lu_waddr == bus.pipe_waddr);
                tail_r             <= tail_r + PTR_W'(1);
            end else begin
                tail_r             <= tail_r;
            end

            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end else begin
                head_r <= head_r;
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.lu_ready = lu_ready_s;
    assign bus.rf_wr    = rf_wr_r;
    assign bus.rf_waddr = rf_waddr_r;
    assign bus.rf_din   = rf_din_r;
    assign bus.chk_hit1 = hit1_s;
    assign bus.chk_hit2 = hit2_s;
    assign bus.pend_cnt = count_r;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed and randomized bench for wb_write_arbiter against a queue-based model of the
// writeback rules (WB priority, kill on younger WB write, r0 suppression).
module tb_wb_write_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                kill;
    } ent_t;

    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    ent_t              m_q[$];
    logic              m_rf_wr    = 1'b0;
    logic [ADDR_W-1:0] m_rf_waddr = 5'd0;
    logic [DATA_W-1:0] m_rf_din   = 32'd0;
    bit                m_acc;
    logic [ADDR_W-1:0] wr_log[$];

    wb_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    wb_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model, check registered outputs.
    task automatic cyc();
        bit   ready;
        bit   h1;
        bit   h2;
        bit   pe;
        ent_t e;
        @(negedge clk);
        ready = !rst && (m_q.size() < DEPTH);
        h1 = 1'b0;
        h2 = 1'b0;
        foreach (m_q[i]) begin
            if (!m_q[i].kill && bus.chk_addr1 != 5'd0 && m_q[i].addr == bus.chk_addr1) h1 = 1'b1;
            if (!m_q[i].kill && bus.chk_addr2 != 5'd0 && m_q[i].addr == bus.chk_addr2) h2 = 1'b1;
        end
        check("lu_ready", bus.lu_ready, ready);
        check("chk_hit1", bus.chk_hit1, h1);
        check("chk_hit2", bus.chk_hit2, h2);
        m_acc = ready && bus.lu_valid;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_rf_wr    = 1'b0;
            m_rf_waddr = 5'd0;
            m_rf_din   = 32'd0;
        end else begin
            pe = bus.pipe_wr && bus.pipe_waddr != 5'd0;
            if (pe) begin
                m_rf_wr    = 1'b1;
                m_rf_waddr = bus.pipe_waddr;
                m_rf_din   = bus.pipe_din;
                foreach (m_q[i]) if (m_q[i].addr == bus.pipe_waddr) m_q[i].kill = 1'b1;
            end else if (m_q.size() > 0) begin
                e          = m_q.pop_front();
                m_rf_wr    = !e.kill;
                m_rf_waddr = e.addr;
                m_rf_din   = e.data;
            end else begin
                m_rf_wr    = 1'b0;
            end
            if (m_acc && bus.lu_waddr != 5'd0) begin
                e.addr = bus.lu_waddr;
                e.data = bus.lu_din;
                e.kill = pe && (bus.lu_waddr == bus.pipe_waddr);
                m_q.push_back(e);
            end
        end
        #1;
        check("rf_wr", bus.rf_wr, m_rf_wr);
        check("rf_waddr", bus.rf_waddr, m_rf_waddr);
        check("rf_din", bus.rf_din, m_rf_din);
        check("pend_cnt", bus.pend_cnt, m_q.size());
        if (bus.rf_wr === 1'b1 && bus.rf_waddr >= 5'd10 && bus.rf_waddr <= 5'd15)
            wr_log.push_back(bus.rf_waddr);
    endtask

    task automatic set_pipe(input logic wr, input logic [4:0] a, input logic [31:0] d);
        bus.pipe_wr = wr; bus.pipe_waddr = a; bus.pipe_din = d;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.lu_valid = v; bus.lu_waddr = a; bus.lu_din = d;
    endtask

    initial begin
        int  budget;
        logic tog;
        rst = 1'b1;
        set_pipe(1'b1, 5'd3, 32'h11);
        set_lu(1'b1, 5'd5, 32'hAA);
        bus.chk_addr1 = 5'd0;
        bus.chk_addr2 = 5'd0;

        // Reset with requests pending
        cyc(); cyc();
        check("rst_rf_wr", bus.rf_wr, 32'd0);
        check("rst_rf_din", bus.rf_din, 32'd0);
        check("rst_pend", bus.pend_cnt, 32'd0);
        rst = 1'b0;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_lu(1'b0, 5'd0, 32'd0);
        cyc();
        check("post_rst_ready", bus.lu_ready, 32'd1);

        // Priority: WB hogs the port while two LU results buffer
        set_pipe(1'b1, 5'd3, 32'h11);
        set_lu(1'b1, 5'd5, 32'hAA);
        bus.chk_addr1 = 5'd5;
        cyc();
        set_lu(1'b1, 5'd6, 32'hBB);
        cyc();
        set_lu(1'b0, 5'd0, 32'd0);
        cyc();
        check("prio_pend2", bus.pend_cnt, 32'd2);
        check("prio_ready0", bus.lu_ready, 32'd0);
        check("prio_hit1", bus.chk_hit1, 32'd1);
        set_pipe(1'b0, 5'd0, 32'd0);
        cyc();
        check("prio_w1_addr", bus.rf_waddr, 32'd5);
        check("prio_w1_data", bus.rf_din, 32'hAA);
        check("prio_pend1", bus.pend_cnt, 32'd1);
        cyc();
        check("prio_w2_addr", bus.rf_waddr, 32'd6);
        check("prio_w2_data", bus.rf_din, 32'hBB);
        check("prio_pend0", bus.pend_cnt, 32'd0);

        // Kill: buffered r7 superseded by a younger WB write
        set_pipe(1'b1, 5'd3, 32'h11);
        set_lu(1'b1, 5'd7, 32'h1234);
        bus.chk_addr1 = 5'd7;
        cyc();
        set_lu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd7, 32'h5678);
        cyc();
        check("kill_wb_data", bus.rf_din, 32'h5678);
        set_pipe(1'b0, 5'd0, 32'd0);
        cyc();
        check("kill_drain_wr", bus.rf_wr, 32'd0);
        check("kill_hit_gone", bus.chk_hit1, 32'd0);

        // Same-cycle kill
        set_pipe(1'b1, 5'd9, 32'h2);
        set_lu(1'b1, 5'd9, 32'h1);
        bus.chk_addr2 = 5'd9;
        cyc();
        check("same_data", bus.rf_din, 32'h2);
        set_pipe(1'b0, 5'd0, 32'd0);
        set_lu(1'b0, 5'd0, 32'd0);
        cyc();
        check("same_no_write", bus.rf_wr, 32'd0);

        // r0 handling on both sources
        set_pipe(1'b1, 5'd3, 32'h11);
        set_lu(1'b1, 5'd4, 32'h44);
        cyc();
        set_pipe(1'b1, 5'd0, 32'hDEAD);
        set_lu(1'b0, 5'd0, 32'd0);
        cyc();
        check("r0_drain_addr", bus.rf_waddr, 32'd4);
        check("r0_drain_data", bus.rf_din, 32'h44);
        set_pipe(1'b0, 5'd0, 32'd0);
        set_lu(1'b1, 5'd0, 32'h99);
        bus.chk_addr1 = 5'd0;
        cyc();
        check("r0_lu_pend", bus.pend_cnt, 32'd0);
        check("r0_lu_nowr", bus.rf_wr, 32'd0);

        // Wrap: six LU results with alternating WB contention on an unrelated register
        wr_log.delete();
        tog = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_lu(1'b1, 5'(10 + k), $urandom);
            budget = 0;
            do begin
                set_pipe(tog, 5'd20, $urandom);
                tog = ~tog;
                cyc();
                budget++;
            end while (!m_acc && budget < 20);
            check("wrap_accept", m_acc, 32'd1);
        end
        set_lu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        repeat (4) cyc();
        check("wrap_count", wr_log.size(), 32'd6);
        for (int k = 0; k < 6 && k < wr_log.size(); k++)
            check("wrap_order", wr_log[k], 32'(10 + k));

        // Randomized traffic with small address range for frequent collisions
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 60) == 0);
            set_pipe(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            set_lu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            bus.chk_addr1 = 5'($urandom_range(0, 7));
            bus.chk_addr2 = 5'($urandom_range(0, 7));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
